// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt unit: Status, Cause, EPC, NUM_IRQ external lines, PC redirect.
// Optional Count/Compare timer interrupt enabled by defining CP0_TIMER_EN.
module cp0_exc_unit #(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic               eret,
  input  logic               mtc0_we,
  input  logic [4:0]         reg_addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [31:0]        epc_in,
  input  logic               pc_valid,
  input  logic [4:0]         dbg_addr,
  output logic [31:0]        dbg_data,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               int_pending
);

  localparam int         IRQ_TOP     = 8 + NUM_IRQ - 1;
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [NUM_IRQ-1:0] im_r;
  logic [NUM_IRQ-1:0] ip_r;
  logic [NUM_IRQ-1:0] ip_s;
  logic               exl_r;
  logic               ie_r;
  logic [4:0]         exc_code_r;
  logic [31:0]        epc_r;
  logic               redirect_r;
  logic [31:0]        redirect_pc_r;
  logic               ti_s;
  logic [31:0]        count_s;
  logic [31:0]        compare_s;
  logic [31:0]        status_s;
  logic [31:0]        cause_s;
  logic               take_int_s;
  logic               mtc0_s;

  function automatic logic [31:0] cp0_mux(input logic [4:0]  addr,
                                          input logic [31:0] status,
                                          input logic [31:0] cause,
                                          input logic [31:0] epc,
                                          input logic [31:0] count,
                                          input logic [31:0] compare);
    logic [31:0] v;
    case (addr)
      REG_COUNT:   v = count;
      REG_COMPARE: v = compare;
      REG_STATUS:  v = status;
      REG_CAUSE:   v = cause;
      REG_EPC:     v = epc;
      default:     v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // An interrupt is only taken when it is the sole event of the cycle and no redirect is in flight.
  assign int_pending = (|(ip_s & im_r)) & ie_r & ~exl_r;
  assign take_int_s  = int_pending & pc_valid & ~exc_req & ~eret & ~mtc0_we & ~redirect_r;
  assign mtc0_s      = mtc0_we & ~exc_req & ~eret;

`ifdef CP0_TIMER_EN
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        ti_r;
  logic [31:0] count_nxt_s;

  assign count_nxt_s = (mtc0_s && (reg_addr == REG_COUNT)) ? wdata : count_r + 32'd1;

  // Free-running Count with Compare match; a Compare write wins over a simultaneous match.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= 32'h0000_0000;
      compare_r <= 32'h0000_0000;
      ti_r      <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (mtc0_s && (reg_addr == REG_COMPARE)) begin
        compare_r <= wdata;
        ti_r      <= 1'b0;
      end else if (count_nxt_s == compare_r) begin
        ti_r <= 1'b1;
      end
    end
  end

  assign ti_s      = ti_r;
  assign count_s   = count_r;
  assign compare_s = compare_r;
`else
  assign ti_s      = 1'b0;
  assign count_s   = 32'h0000_0000;
  assign compare_s = 32'h0000_0000;
`endif

  // Register images as software sees them; the timer shares the top IP bit.
  always_comb begin
    ip_s                 = ip_r;
    ip_s[NUM_IRQ-1]      = ip_r[NUM_IRQ-1] | ti_s;
    status_s             = 32'h0000_0000;
    status_s[IRQ_TOP:8]  = im_r;
    status_s[1]          = exl_r;
    status_s[0]          = ie_r;
    cause_s              = 32'h0000_0000;
    cause_s[30]          = ti_s;
    cause_s[IRQ_TOP:8]   = ip_s;
    cause_s[6:2]         = exc_code_r;
  end

  assign rdata    = cp0_mux(reg_addr, status_s, cause_s, epc_r, count_s, compare_s);
  assign dbg_data = cp0_mux(dbg_addr, status_s, cause_s, epc_r, count_s, compare_s);

  // Single prioritised action per cycle: exception > interrupt > eret > mtc0.
  always_ff @(posedge clk) begin
    if (rst) begin
      im_r          <= '0;
      ip_r          <= '0;
      exl_r         <= 1'b0;
      ie_r          <= 1'b0;
      exc_code_r    <= 5'd0;
      epc_r         <= 32'h0000_0000;
      redirect_r    <= 1'b0;
      redirect_pc_r <= 32'h0000_0000;
    end else begin
      ip_r       <= irq;
      redirect_r <= 1'b0;
      if (exc_req || take_int_s) begin
        if (!exl_r) begin
          epc_r <= epc_in;
        end
        exc_code_r    <= exc_req ? exc_code : 5'd0;
        exl_r         <= 1'b1;
        redirect_r    <= 1'b1;
        redirect_pc_r <= EXC_VECTOR;
      end else if (eret) begin
        exl_r         <= 1'b0;
        redirect_r    <= 1'b1;
        redirect_pc_r <= epc_r;
      end else if (mtc0_s) begin
        case (reg_addr)
          REG_STATUS: begin
            im_r  <= wdata[IRQ_TOP:8];
            exl_r <= wdata[1];
            ie_r  <= wdata[0];
          end
          REG_EPC: epc_r <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign redirect    = redirect_r;
  assign redirect_pc = redirect_pc_r;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios then random traffic vs a behavioural model.
// Timer checks are active when CP0_TIMER_EN is defined.
module tb_cp0_exc_unit;
  localparam int          NIRQ   = 6;
  localparam logic [31:0] VEC    = 32'h0000_0000;
  localparam logic [31:0] IRQ_MASK    = (32'd1 << NIRQ) - 32'd1;
  localparam logic [31:0] STATUS_MASK = (IRQ_MASK << 8) | 32'd3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] irq;
  logic            exc_req;
  logic [4:0]      exc_code;
  logic            eret;
  logic            mtc0_we;
  logic [4:0]      reg_addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [31:0]     epc_in;
  logic            pc_valid;
  logic [4:0]      dbg_addr;
  logic [31:0]     dbg_data;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic            int_pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural view of CP0 kept by the bench.
  logic [31:0] m_status, m_epc, m_count, m_compare, m_irq_q, m_rpc;
  logic [4:0]  m_exccode;
  logic        m_ti, m_redirect;

  cp0_exc_unit #(.NUM_IRQ(NIRQ), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .irq(irq), .exc_req(exc_req), .exc_code(exc_code),
    .eret(eret), .mtc0_we(mtc0_we), .reg_addr(reg_addr), .wdata(wdata),
    .rdata(rdata), .epc_in(epc_in), .pc_valid(pc_valid), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_ip();
    return (m_irq_q & IRQ_MASK) | (32'(m_ti) << (NIRQ - 1));
  endfunction

  function automatic logic m_pending();
    logic [31:0] im;
    im = (m_status >> 8) & IRQ_MASK;
    return ((m_ip() & im) != 32'd0) && m_status[0] && !m_status[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      5'd12: return m_status;
      5'd13: return (32'(m_ti) << 30) | (m_ip() << 8) | (32'(m_exccode) << 2);
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic take_int, wr_ok;
    logic [31:0] old_epc, cnt_next;
    if (rst) begin
      m_status = 0; m_epc = 0; m_count = 0; m_compare = 0; m_irq_q = 0;
      m_rpc = 0; m_exccode = 0; m_ti = 0; m_redirect = 0;
      return;
    end
    old_epc  = m_epc;
    take_int = m_pending() && pc_valid && !exc_req && !eret && !mtc0_we && !m_redirect;
    wr_ok    = mtc0_we && !exc_req && !eret;
    m_redirect = 1'b0;
    if (exc_req || take_int) begin
      if (!m_status[1]) m_epc = epc_in;
      m_exccode  = exc_req ? exc_code : 5'd0;
      m_status   = m_status | 32'd2;
      m_redirect = 1'b1;
      m_rpc      = VEC;
    end else if (eret) begin
      m_status   = m_status & ~32'd2;
      m_redirect = 1'b1;
      m_rpc      = old_epc;
    end else if (wr_ok) begin
      if (reg_addr == 5'd12) m_status = wdata & STATUS_MASK;
      if (reg_addr == 5'd14) m_epc = wdata;
    end
`ifdef CP0_TIMER_EN
    cnt_next = (wr_ok && reg_addr == 5'd9) ? wdata : m_count + 32'd1;
    if (wr_ok && reg_addr == 5'd11) begin
      m_compare = wdata;
      m_ti      = 1'b0;
    end else if (cnt_next == m_compare) begin
      m_ti = 1'b1;
    end
    m_count = cnt_next;
`else
    cnt_next = 32'd0;
`endif
    m_irq_q = 32'(irq);
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic tick();
    #1;
    check("rdata", rdata, m_read(reg_addr));
    check("dbg_data", dbg_data, m_read(dbg_addr));
    check("int_pending", {31'd0, int_pending}, {31'd0, m_pending()});
    check("redirect", {31'd0, redirect}, {31'd0, m_redirect});
    if (m_redirect) check("redirect_pc", redirect_pc, m_rpc);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    exc_req = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); mtc0_we = 1'b1; reg_addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    reg_addr = a; dbg_addr = a;
    #1;
    check(tag, rdata, exp);
    check({tag, "_dbg"}, dbg_data, exp);
  endtask

  initial begin
    int n;
    rst = 1'b1; irq = '0; exc_req = 0; exc_code = 0; eret = 0; mtc0_we = 0;
    reg_addr = 0; wdata = 0; epc_in = 0; pc_valid = 0; dbg_addr = 0;
    @(negedge clk);
    @(posedge clk); model_step(); @(negedge clk);
    tick();
    rst = 1'b0;
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    read_chk("rst_status", 5'd12, 32'd0);
    read_chk("rst_cause", 5'd13, 32'd0);
    read_chk("rst_epc", 5'd14, 32'd0);

    mtc0(5'd12, 32'h0000_0401);
    read_chk("status_wr", 5'd12, 32'h0000_0401);
    read_chk("cause_zero", 5'd13, 32'd0);

    exc_req = 1'b1; exc_code = 5'd8; epc_in = 32'h0000_0040;
    tick(); idle();
    check("exc_redirect", {31'd0, redirect}, 32'd1);
    check("exc_redirect_pc", redirect_pc, 32'h0);
    read_chk("exc_epc", 5'd14, 32'h0000_0040);
    read_chk("exc_cause", 5'd13, 32'h0000_0020);
    read_chk("exc_status", 5'd12, 32'h0000_0403);
    tick();
    check("exc_redirect_one", {31'd0, redirect}, 32'd0);
    eret = 1'b1;
    tick(); idle();
    check("eret_redirect", {31'd0, redirect}, 32'd1);
    check("eret_pc", redirect_pc, 32'h0000_0040);
    read_chk("eret_status", 5'd12, 32'h0000_0401);
    tick();

    mtc0(5'd12, 32'h0000_0101);
    tick();
    irq = 6'b000001; pc_valid = 1'b1; epc_in = 32'h0000_0080;
    tick();
    irq = '0;
    #1 check("irq_pending", {31'd0, int_pending}, 32'd1);
    check("irq_no_early", {31'd0, redirect}, 32'd0);
    tick();
    check("irq_redirect", {31'd0, redirect}, 32'd1);
    check("irq_redirect_pc", redirect_pc, VEC);
    read_chk("irq_epc", 5'd14, 32'h0000_0080);
    read_chk("irq_cause", 5'd13, 32'd0);
    irq = 6'b000001;
    for (int i = 0; i < 4; i++) tick();
    check("irq_exl_block", {31'd0, redirect}, 32'd0);
    irq = '0;
    tick();
    eret = 1'b1; tick(); idle(); tick(); tick();

    exc_req = 1'b1; exc_code = 5'd8; epc_in = 32'h0000_0200;
    mtc0_we = 1'b1; reg_addr = 5'd14; wdata = 32'h0000_1234;
    tick(); idle();
    read_chk("exc_beats_mtc0", 5'd14, 32'h0000_0200);
    tick();
    eret = 1'b1; mtc0_we = 1'b1; reg_addr = 5'd14; wdata = 32'h0000_5555;
    tick(); idle();
    check("eret_beats_mtc0_pc", redirect_pc, 32'h0000_0200);
    read_chk("eret_beats_mtc0", 5'd14, 32'h0000_0200);
    read_chk("eret_exl_clr", 5'd12, 32'h0000_0101);
    tick();

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'd100);
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_2001);
    mtc0(5'd9, 32'd0);
    n = 0;
    while (!redirect && n < 20) begin
      tick();
      n++;
    end
    check("timer_latency", 32'(n), 32'd6);
    read_chk("timer_cause", 5'd13, 32'h4000_2000);
    mtc0(5'd11, 32'd100);
    read_chk("timer_ti_clr", 5'd13, 32'd0);
`endif

    exc_req = 1'b1; exc_code = 5'd8; epc_in = 32'h0000_0300;
    tick(); idle();
    check("pre_rst_redirect", {31'd0, redirect}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_redirect", {31'd0, redirect}, 32'd0);
    check("rst_mid_pc", redirect_pc, 32'd0);
    read_chk("rst_mid_status", 5'd12, 32'd0);
    read_chk("rst_mid_epc", 5'd14, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      exc_req  = ($urandom_range(0, 9) == 0);
      exc_code = 5'($urandom);
      eret     = ($urandom_range(0, 9) == 0);
      mtc0_we  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: reg_addr = 5'd9;
        1: reg_addr = 5'd11;
        2: reg_addr = 5'd12;
        3: reg_addr = 5'd13;
        4: reg_addr = 5'd14;
        default: reg_addr = 5'($urandom);
      endcase
      wdata    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      dbg_addr = 5'($urandom_range(9, 14));
      epc_in   = $urandom;
      pc_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) irq = NIRQ'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Parametrised coprocessor-0 exception and interrupt unit for the single-cycle/multi-cycle MIPS core. It holds Status, Cause, EPC and, optionally, Count/Compare. It services SYSCALL-class exceptions, ERET and MTC0/MFC0 like the first-generation CP0 register file. It adds `NUM_IRQ` maskable external interrupt lines, a registered one-cycle PC redirect handshake to the fetch stage, and an optional timer interrupt.

## Interface
- `NUM_IRQ`, 6, number of external interrupt lines, legal 1..8; line i maps to Status.IM/Cause.IP bit 8+i
- `EXC_VECTOR`, 32'h0000_0000, redirect target on exception/interrupt entry
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `irq` in NUM_IRQ — level-sensitive external interrupt requests
- `exc_req` in 1 — synchronous exception (SYSCALL etc.) this cycle
- `exc_code` in 5 — ExcCode for `exc_req` (SYSCALL = 8)
- `eret` in 1 — ERET executing this cycle
- `mtc0_we` in 1 — MTC0 write strobe
- `reg_addr` in 5 — CP0 register number for MTC0/MFC0
- `wdata` in 32 — MTC0 data
- `rdata` out 32 — MFC0 data, combinational from `reg_addr`
- `epc_in` in 32 — PC to resume at (faulting PC for exceptions, next-to-execute PC for interrupts)
- `pc_valid` in 1 — `epc_in` valid; interrupts are only taken when 1
- `dbg_addr` in 5 / `dbg_data` out 32 — second combinational read port for the board display
- `redirect` out 1 — one-cycle pulse: fetch must load `redirect_pc`
- `redirect_pc` out 32 — target PC, valid while `redirect`=1
- `int_pending` out 1 — |(IP & IM) & IE & ~EXL, combinational

## Operation
- Registers: Status(12) {IM[8+NUM_IRQ-1:8], EXL[1], IE[0]}; Cause(13) {TI[30], IP[8+NUM_IRQ-1:8], ExcCode[6:2]}; EPC(14); Count(9), Compare(11) with timer. Unimplemented bits/registers read 0.
- MTC0 writable: Status IM/EXL/IE, EPC, Count, Compare. Writes to Cause and other numbers are ignored.
- IP[8+i] is `irq[i]` registered every cycle. With timer, bit 8+NUM_IRQ-1 is `irq[NUM_IRQ-1] | TI`.
- Per-cycle priority, one action only: exc_req > interrupt > eret > mtc0_we.
- Exception entry (`exc_req`): EPC<=`epc_in` only if EXL=0; ExcCode<=`exc_code`; EXL<=1; next cycle redirect=1, redirect_pc=EXC_VECTOR.
- Interrupt entry conditions: `int_pending`, `pc_valid`=1, no `exc_req`/`eret`/`mtc0_we` this cycle, and `redirect`=0.
- Interrupt entry actions: as exception entry with ExcCode=0.
- ERET: EXL<=0; next cycle redirect=1, redirect_pc=EPC value before this edge.
- Losing MTC0 in a simultaneous event is dropped, not deferred.

## Timing
- Reset: Status=0, Cause=0, EPC=0, Count=0, Compare=0, redirect=0, redirect_pc=0.
- MFC0 read is same-cycle combinational. An MTC0 write is visible on `rdata` the cycle after its edge.
- irq rises before edge E0: IP set at E0; entry at E1 if conditions hold; `redirect` high E1–E2.
- exc_req/eret at edge E: `redirect` high for exactly the cycle after E.
- `rst` mid-redirect: `redirect` is 0 in the cycle after the reset edge.
- Timer: Count+=1 every cycle, wrapping 32'hFFFF_FFFF->0. MTC0 to Count loads `wdata` instead of incrementing.
- TI sets on the edge where the new Count equals Compare. MTC0 to Compare clears TI. Set and clear on the same edge resolves as clear.

## Configuration
- `CP0_TIMER_EN` defined: Count/Compare/TI implemented as above.
- `CP0_TIMER_EN` undefined: registers 9/11 read 0, writes ignored, TI=0, no timer logic synthesised.

## Test plan
- Reset, then MTC0 Status=32'h0000_0401, MFC0 12 -> 32'h0000_0401; MFC0 13 -> 0.
- exc_req, exc_code=8, epc_in=32'h0000_0040 -> EPC=0x40, Cause=32'h0000_0020, EXL=1, one-cycle redirect to 0x0. Then eret -> EXL=0, redirect_pc=0x40.
- IE=1, IM[8]=1, irq[0] pulsed, pc_valid=1, epc_in=0x80 -> entry 2 edges after irq, ExcCode=0, EPC=0x80. Then irq held with EXL=1 -> no second redirect.
- exc_req and mtc0_we (EPC=0x1234) same cycle -> exception taken, EPC=epc_in, write dropped. eret and mtc0 same cycle -> eret wins.
- (CP0_TIMER_EN) Compare=5, Count=0, IE=1, IM top bit=1 -> TI set when Count reaches 5, interrupt taken next edge. MTC0 Compare clears TI.
- Assert rst while redirect pending -> all outputs return to reset values on that edge.
